// File: rtl/stack_op_pkg.sv
// Shared types and helpers for the stack op sequencer.
// Opcode/error/state encodings, ALU evaluation and operand depth table.
package stack_op_pkg;

    localparam int ALU_W = 64;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_PUSH = 4'd1,
        OP_DROP = 4'd2,
        OP_DUP  = 4'd3,
        OP_SWAP = 4'd4,
        OP_OVER = 4'd5,
        OP_ROT  = 4'd6,
        OP_ADD  = 4'd7,
        OP_SUB  = 4'd8,
        OP_AND  = 4'd9,
        OP_OR   = 4'd10,
        OP_XOR  = 4'd11
    } op_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_UNDER   = 2'd1,
        ERR_OVER    = 2'd2,
        ERR_ILLEGAL = 2'd3
    } err_t;

    typedef enum logic [4:0] {
        S_IDLE,
        S_ERR,
        S_NOP,
        S_PUSH,
        S_DROP,
        S_PEEK0,
        S_PEEK1,
        S_PEEK2,
        S_PUSH_A,
        S_PUSH_B,
        S_SWP_P0,
        S_SWP_P1,
        S_ROT_P0,
        S_ROT_P1,
        S_ROT_P2,
        S_ALU_POP,
        S_ALU_P0
    } state_t;

    // n is the second-from-top (N), t the top (T); caller truncates.
    function automatic logic [ALU_W-1:0] alu_apply(
        input op_t              op,
        input logic [ALU_W-1:0] n,
        input logic [ALU_W-1:0] t
    );
        case (op)
            OP_ADD:  return n + t;
            OP_SUB:  return n - t;
            OP_AND:  return n & t;
            OP_OR:   return n | t;
            OP_XOR:  return n ^ t;
            default: return n;
        endcase
    endfunction

    function automatic logic [1:0] req_depth(input op_t op);
        case (op)
            OP_DROP, OP_DUP:          return 2'd1;
            OP_SWAP, OP_OVER:         return 2'd2;
            OP_ROT:                   return 2'd3;
            OP_ADD, OP_SUB, OP_AND,
            OP_OR, OP_XOR:            return 2'd2;
            default:                  return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/stack_op_sequencer.sv
// Command sequencer driving a LIFO stack with single-strobe cycles.
// Implements PUSH/DROP/DUP/SWAP/OVER/ROT and binary ALU ops.
module stack_op_sequencer
    import stack_op_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 256,
    localparam int IDX_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       op_code,
    input  logic [WIDTH-1:0] op_imm,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic             stk_push_en,
    output logic             stk_pop_en,
    output logic             stk_peek_en,
    output logic             stk_poke_en,
    output logic [WIDTH-1:0] stk_data_in,
    output logic [IDX_W-1:0] stk_index,
    input  logic [WIDTH-1:0] stk_data_out,
    input  logic             stk_full,
    input  logic             stk_empty,
    input  logic [IDX_W-1:0] stk_depth
);

    state_t           r_state;
    state_t           w_next;
    state_t           w_first;
    op_t              r_op;
    err_t             r_err_code;
    err_t             w_code;
    logic [WIDTH-1:0] r_imm;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_c;

    op_t              w_op;
    logic             w_accept;
    logic             w_illegal;
    logic             w_under;
    logic             w_over;
    logic [IDX_W-1:0] w_req;
    logic [ALU_W-1:0] w_alu;
    logic [ALU_W-WIDTH-1:0] w_alu_unused;

    assign w_op      = op_t'(op_code);
    assign op_ready  = (r_state == S_IDLE);
    assign w_accept  = op_valid && op_ready;
    assign w_illegal = (op_code >= 4'd12);
    assign w_req     = {{(IDX_W-2){1'b0}}, req_depth(w_op)};
    assign w_under   = (w_req != '0) && (stk_empty || (stk_depth < w_req));
    assign w_over    = stk_full && (w_op inside {OP_PUSH, OP_DUP, OP_OVER});
    assign err_code  = r_err_code;

    assign w_alu        = alu_apply(r_op, ALU_W'(r_b), ALU_W'(r_a));
    assign w_alu_unused = w_alu[ALU_W-1:WIDTH];

    always_comb begin
        w_code = ERR_NONE;
        if (w_illegal)   w_code = ERR_ILLEGAL;
        else if (w_under) w_code = ERR_UNDER;
        else if (w_over)  w_code = ERR_OVER;
    end

    always_comb begin
        w_first = S_PEEK0;
        case (w_op)
            OP_NOP:  w_first = S_NOP;
            OP_PUSH: w_first = S_PUSH;
            OP_DROP: w_first = S_DROP;
            OP_OVER: w_first = S_PEEK1;
            default: w_first = S_PEEK0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept)
                    w_next = (w_code != ERR_NONE) ? S_ERR : w_first;
            end
            S_PEEK0: w_next = (r_op == OP_DUP) ? S_PUSH_A : S_PEEK1;
            S_PEEK1: begin
                case (r_op)
                    OP_OVER: w_next = S_PUSH_B;
                    OP_SWAP: w_next = S_SWP_P0;
                    OP_ROT:  w_next = S_PEEK2;
                    default: w_next = S_ALU_POP;
                endcase
            end
            S_PEEK2:   w_next = S_ROT_P0;
            S_SWP_P0:  w_next = S_SWP_P1;
            S_ROT_P0:  w_next = S_ROT_P1;
            S_ROT_P1:  w_next = S_ROT_P2;
            S_ALU_POP: w_next = S_ALU_P0;
            default:   w_next = S_IDLE;
        endcase
    end

    // Strobes and handshake outputs decode from the state register only.
    always_comb begin
        done        = 1'b0;
        err         = 1'b0;
        stk_push_en = 1'b0;
        stk_pop_en  = 1'b0;
        stk_peek_en = 1'b0;
        stk_poke_en = 1'b0;
        stk_data_in = '0;
        stk_index   = '0;
        unique case (r_state)
            S_IDLE:    ;
            S_ERR:     err = 1'b1;
            S_NOP:     done = 1'b1;
            S_PUSH:    begin stk_push_en = 1'b1; stk_data_in = r_imm; done = 1'b1; end
            S_DROP:    begin stk_pop_en = 1'b1; done = 1'b1; end
            S_PEEK0:   stk_peek_en = 1'b1;
            S_PEEK1:   begin stk_peek_en = 1'b1; stk_index = IDX_W'(1); end
            S_PEEK2:   begin stk_peek_en = 1'b1; stk_index = IDX_W'(2); end
            S_PUSH_A:  begin stk_push_en = 1'b1; stk_data_in = r_a; done = 1'b1; end
            S_PUSH_B:  begin stk_push_en = 1'b1; stk_data_in = r_b; done = 1'b1; end
            S_SWP_P0:  begin stk_poke_en = 1'b1; stk_data_in = r_b; end
            S_SWP_P1:  begin
                stk_poke_en = 1'b1;
                stk_index   = IDX_W'(1);
                stk_data_in = r_a;
                done        = 1'b1;
            end
            S_ROT_P0:  begin stk_poke_en = 1'b1; stk_data_in = r_c; end
            S_ROT_P1:  begin stk_poke_en = 1'b1; stk_index = IDX_W'(1); stk_data_in = r_a; end
            S_ROT_P2:  begin
                stk_poke_en = 1'b1;
                stk_index   = IDX_W'(2);
                stk_data_in = r_b;
                done        = 1'b1;
            end
            S_ALU_POP: stk_pop_en = 1'b1;
            S_ALU_P0:  begin stk_poke_en = 1'b1; stk_data_in = w_alu[WIDTH-1:0]; done = 1'b1; end
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_op       <= OP_NOP;
            r_err_code <= ERR_NONE;
            r_imm      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_c        <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op       <= w_op;
                r_imm      <= op_imm;
                r_err_code <= w_code;
            end
            if (r_state == S_PEEK0) r_a <= stk_data_out;
            if (r_state == S_PEEK1) r_b <= stk_data_out;
            if (r_state == S_PEEK2) r_c <= stk_data_out;
        end
    end

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Directed bench for stack_op_sequencer against a small behavioural stack.
// Each scenario task checks its own results inline.
module tb_stack_op_sequencer;
    import stack_op_pkg::*;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          op_valid = 1'b0;
    logic          op_ready;
    logic [3:0]    op_code = 4'd0;
    logic [W-1:0]  op_imm = '0;
    logic          done, err;
    logic [1:0]    err_code;
    logic          stk_push_en, stk_pop_en, stk_peek_en, stk_poke_en;
    logic [W-1:0]  stk_data_in;
    logic [IW-1:0] stk_index;
    logic [W-1:0]  stk_data_out;
    logic          stk_full, stk_empty;
    logic [IW-1:0] stk_depth;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    stack_op_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_imm(op_imm),
        .done(done), .err(err), .err_code(err_code),
        .stk_push_en(stk_push_en), .stk_pop_en(stk_pop_en),
        .stk_peek_en(stk_peek_en), .stk_poke_en(stk_poke_en),
        .stk_data_in(stk_data_in), .stk_index(stk_index),
        .stk_data_out(stk_data_out),
        .stk_full(stk_full), .stk_empty(stk_empty),
        .stk_depth(stk_depth)
    );

    // Behavioural LIFO: index 0 is the top entry.
    logic [W-1:0]  mem [D];
    logic [IW-1:0] depth;
    logic [IW-1:0] rd_addr;

    assign rd_addr      = depth - 3'd1 - stk_index;
    assign stk_data_out = stk_peek_en ? mem[rd_addr[1:0]] : '0;
    assign stk_full     = (depth == 3'(D));
    assign stk_empty    = (depth == 3'd0);
    assign stk_depth    = depth;

    always @(posedge clk) begin
        if (!rst_n) begin
            depth <= '0;
        end else if (stk_push_en && depth != 3'(D)) begin
            mem[depth[1:0]] <= stk_data_in;
            depth <= depth + 3'd1;
        end else if (stk_pop_en && depth != 3'd0) begin
            depth <= depth - 3'd1;
        end else if (stk_poke_en) begin
            mem[rd_addr[1:0]] <= stk_data_in;
        end
    end

    int c_push = 0, c_pop = 0, c_peek = 0, c_poke = 0, c_multi = 0;
    always @(posedge clk) begin
        c_push <= c_push + int'(stk_push_en);
        c_pop  <= c_pop  + int'(stk_pop_en);
        c_peek <= c_peek + int'(stk_peek_en);
        c_poke <= c_poke + int'(stk_poke_en);
        if (int'(stk_push_en) + int'(stk_pop_en) +
            int'(stk_peek_en) + int'(stk_poke_en) > 1)
            c_multi <= c_multi + 1;
    end

    function automatic logic [W-1:0] top_at(input logic [IW-1:0] i);
        logic [IW-1:0] a;
        a = depth - 3'd1 - i;
        return mem[a[1:0]];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        op_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Issues one command; cyc is the C-index where done/err was seen.
    task automatic run_op(input logic [3:0] code, input logic [W-1:0] imm,
                          output int cyc, output bit got_done,
                          output bit got_err, output int nrdy);
        int k;
        @(negedge clk);
        op_valid = 1'b1;
        op_code  = code;
        op_imm   = imm;
        @(negedge clk);
        op_valid = 1'b0;
        op_code  = 4'd0;
        op_imm   = '0;
        k = 1;
        got_done = 1'b0;
        got_err  = 1'b0;
        nrdy     = 0;
        while (k <= 20) begin
            if (!op_ready) nrdy++;
            if (done) got_done = 1'b1;
            if (err)  got_err  = 1'b1;
            if (done || err) break;
            @(negedge clk);
            k++;
        end
        cyc = k;
        n_cmp++;
        if (k > 20) begin
            n_fail++;
            $display("FAIL timeout op=%0d cycles=%0d required<=20", code, k);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({op_ready, done, err} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_hs rdy/done/err=%b required 100", {op_ready, done, err});
        end
        n_cmp++;
        if (err_code !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_errcode got=%0d required 0", err_code);
        end
        n_cmp++;
        if ({stk_push_en, stk_pop_en, stk_peek_en, stk_poke_en} !== 4'b0 ||
            stk_index !== 3'd0 || stk_data_in !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_strobes str=%b idx=%0d din=%h required 0",
                     {stk_push_en, stk_pop_en, stk_peek_en, stk_poke_en},
                     stk_index, stk_data_in);
        end
    endtask

    task automatic test_push_dup();
        int cyc, nr, p0, k0;
        bit gd, ge;
        do_reset();
        run_op(4'd1, 8'h11, cyc, gd, ge, nr);
        n_cmp++;
        if (cyc !== 1 || !gd) begin
            n_fail++;
            $display("FAIL push_lat got=%0d required 1", cyc);
        end
        run_op(4'd1, 8'h22, cyc, gd, ge, nr);
        p0 = c_push;
        k0 = c_peek;
        run_op(4'd3, 8'h00, cyc, gd, ge, nr);
        n_cmp++;
        if (cyc !== 2 || nr !== 2) begin
            n_fail++;
            $display("FAIL dup_lat got cyc=%0d nrdy=%0d required 2/2", cyc, nr);
        end
        n_cmp++;
        if (depth !== 3'd3) begin
            n_fail++;
            $display("FAIL dup_depth got=%0d required 3", depth);
        end
        n_cmp++;
        if (top_at(0) !== 8'h22 || top_at(1) !== 8'h22 || top_at(2) !== 8'h11) begin
            n_fail++;
            $display("FAIL dup_data got=%h %h %h required 22 22 11",
                     top_at(0), top_at(1), top_at(2));
        end
        n_cmp++;
        if (c_push - p0 !== 1 || c_peek - k0 !== 1) begin
            n_fail++;
            $display("FAIL dup_strobes push=%0d peek=%0d required 1/1",
                     c_push - p0, c_peek - k0);
        end
    endtask

    task automatic test_over_drop();
        int cyc, nr;
        bit gd, ge;
        do_reset();
        run_op(4'd1, 8'h11, cyc, gd, ge, nr);
        run_op(4'd1, 8'h22, cyc, gd, ge, nr);
        run_op(4'd5, 8'h00, cyc, gd, ge, nr);
        n_cmp++;
        if (cyc !== 2 || depth !== 3'd3 || top_at(0) !== 8'h11) begin
            n_fail++;
            $display("FAIL over got cyc=%0d depth=%0d top=%h required 2 3 11",
                     cyc, depth, top_at(0));
        end
        run_op(4'd2, 8'h00, cyc, gd, ge, nr);
        n_cmp++;
        if (cyc !== 1 || depth !== 3'd2 || top_at(0) !== 8'h22) begin
            n_fail++;
            $display("FAIL drop got cyc=%0d depth=%0d top=%h required 1 2 22",
                     cyc, depth, top_at(0));
        end
        run_op(4'd0, 8'h00, cyc, gd, ge, nr);
        n_cmp++;
        if (cyc !== 1 || !gd || depth !== 3'd2) begin
            n_fail++;
            $display("FAIL nop got cyc=%0d depth=%0d required 1 2", cyc, depth);
        end
    endtask

    task automatic test_swap();
        int cyc, nr, k0, q0;
        bit gd, ge;
        do_reset();
        run_op(4'd1, 8'h11, cyc, gd, ge, nr);
        run_op(4'd1, 8'h22, cyc, gd, ge, nr);
        k0 = c_peek;
        q0 = c_poke;
        run_op(4'd4, 8'h00, cyc, gd, ge, nr);
        n_cmp++;
        if (cyc !== 4 || c_peek - k0 !== 2 || c_poke - q0 !== 2) begin
            n_fail++;
            $display("FAIL swap_seq got cyc=%0d peek=%0d poke=%0d required 4 2 2",
                     cyc, c_peek - k0, c_poke - q0);
        end
        n_cmp++;
        if (depth !== 3'd2 || top_at(0) !== 8'h11 || top_at(1) !== 8'h22) begin
            n_fail++;
            $display("FAIL swap_data got depth=%0d %h %h required 2 11 22",
                     depth, top_at(0), top_at(1));
        end
    endtask

    task automatic test_rot();
        int cyc, nr;
        bit gd, ge;
        do_reset();
        run_op(4'd1, 8'h01, cyc, gd, ge, nr);
        run_op(4'd1, 8'h02, cyc, gd, ge, nr);
        run_op(4'd1, 8'h03, cyc, gd, ge, nr);
        run_op(4'd6, 8'h00, cyc, gd, ge, nr);
        n_cmp++;
        if (cyc !== 6) begin
            n_fail++;
            $display("FAIL rot_lat got=%0d required 6", cyc);
        end
        n_cmp++;
        if (top_at(0) !== 8'h01 || top_at(1) !== 8'h03 || top_at(2) !== 8'h02) begin
            n_fail++;
            $display("FAIL rot_data got=%h %h %h required 01 03 02",
                     top_at(0), top_at(1), top_at(2));
        end
    endtask

    task automatic test_alu();
        logic [7:0] va [5] = '{8'hF0, 8'h05, 8'hF0, 8'hF0, 8'hF0};
        logic [7:0] vb [5] = '{8'h20, 8'h07, 8'h3C, 8'h3C, 8'h3C};
        logic [3:0] vo [5] = '{4'd7, 4'd8, 4'd11, 4'd9, 4'd10};
        logic [7:0] ve [5] = '{8'h10, 8'hFE, 8'hCC, 8'h30, 8'hFC};
        int cyc, nr;
        bit gd, ge;
        for (int i = 0; i < 5; i++) begin
            do_reset();
            run_op(4'd1, va[i], cyc, gd, ge, nr);
            run_op(4'd1, vb[i], cyc, gd, ge, nr);
            run_op(vo[i], 8'h00, cyc, gd, ge, nr);
            n_cmp++;
            if (cyc !== 4 || depth !== 3'd1 || top_at(0) !== ve[i]) begin
                n_fail++;
                $display("FAIL alu op=%0d got cyc=%0d depth=%0d top=%h required 4 1 %h",
                         vo[i], cyc, depth, top_at(0), ve[i]);
            end
        end
    endtask

    task automatic test_errors();
        int cyc, nr, s0;
        bit gd, ge;
        do_reset();
        s0 = c_push + c_pop + c_peek + c_poke;
        run_op(4'd2, 8'h00, cyc, gd, ge, nr);
        n_cmp++;
        if (!ge || gd || cyc !== 1 || err_code !== 2'd1) begin
            n_fail++;
            $display("FAIL err_under got err=%0d done=%0d cyc=%0d code=%0d required 1 0 1 1",
                     ge, gd, cyc, err_code);
        end
        n_cmp++;
        if (c_push + c_pop + c_peek + c_poke - s0 !== 0 || depth !== 3'd0) begin
            n_fail++;
            $display("FAIL err_nostrobe got strobes=%0d depth=%0d required 0 0",
                     c_push + c_pop + c_peek + c_poke - s0, depth);
        end
        for (int i = 0; i < 4; i++)
            run_op(4'd1, 8'(i), cyc, gd, ge, nr);
        run_op(4'd1, 8'h99, cyc, gd, ge, nr);
        n_cmp++;
        if (!ge || err_code !== 2'd2 || depth !== 3'd4) begin
            n_fail++;
            $display("FAIL err_over got err=%0d code=%0d depth=%0d required 1 2 4",
                     ge, err_code, depth);
        end
        run_op(4'd13, 8'h00, cyc, gd, ge, nr);
        n_cmp++;
        if (!ge || err_code !== 2'd3) begin
            n_fail++;
            $display("FAIL err_illegal got err=%0d code=%0d required 1 3", ge, err_code);
        end
        run_op(4'd0, 8'h00, cyc, gd, ge, nr);
        n_cmp++;
        if (!gd || ge || err_code !== 2'd0) begin
            n_fail++;
            $display("FAIL err_clear got done=%0d err=%0d code=%0d required 1 0 0",
                     gd, ge, err_code);
        end
        do_reset();
        run_op(4'd12, 8'h00, cyc, gd, ge, nr);
        n_cmp++;
        if (err_code !== 2'd3) begin
            n_fail++;
            $display("FAIL err_prec got code=%0d required 3", err_code);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, nr, q0, k0;
        bit gd, ge;
        do_reset();
        run_op(4'd1, 8'h01, cyc, gd, ge, nr);
        run_op(4'd1, 8'h02, cyc, gd, ge, nr);
        run_op(4'd1, 8'h03, cyc, gd, ge, nr);
        q0 = c_poke;
        k0 = c_peek;
        @(negedge clk);
        op_valid = 1'b1;
        op_code  = 4'd6;
        @(negedge clk);
        op_valid = 1'b0;
        op_code  = 4'd0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        n_cmp++;
        if (c_poke - q0 !== 0 || c_peek - k0 !== 2) begin
            n_fail++;
            $display("FAIL midrst_strobes got poke=%0d peek=%0d required 0 2",
                     c_poke - q0, c_peek - k0);
        end
        n_cmp++;
        if (op_ready !== 1'b1 || depth !== 3'd0) begin
            n_fail++;
            $display("FAIL midrst_state got rdy=%0d depth=%0d required 1 0",
                     op_ready, depth);
        end
    endtask

    initial begin
        test_reset();
        test_push_dup();
        test_over_drop();
        test_swap();
        test_rot();
        test_alu();
        test_errors();
        test_reset_mid();
        n_cmp++;
        if (c_multi !== 0) begin
            n_fail++;
            $display("FAIL one_strobe got multi=%0d required 0", c_multi);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
